// File: rtl/tff_counter_pkg.sv
// ---------------------------------------------------------------------------
// tff_counter_pkg
//   Shared definitions for the T-flip-flop counter bank.
//   The mode encodings select how the per-bit toggle vector is built:
//     MODE_BANK : each bit toggles on its own t_in request
//     MODE_UP   : synchronous increment (prefix-AND toggle chain)
//     MODE_DOWN : synchronous decrement (prefix-NOR toggle chain)
//     MODE_HOLD : no toggles
// ---------------------------------------------------------------------------
package tff_counter_pkg;

   localparam logic [1:0] MODE_BANK = 2'b00;
   localparam logic [1:0] MODE_UP   = 2'b01;
   localparam logic [1:0] MODE_DOWN = 2'b10;
   localparam logic [1:0] MODE_HOLD = 2'b11;

endpackage : tff_counter_pkg

// File: rtl/tff_cell.sv
// ---------------------------------------------------------------------------
// tff_cell
//   One T flip-flop with synchronous reset value and synchronous parallel
//   load. Priority on each rising edge: rst > load > t.
// Ports
//   clk     in  1  rising-edge clock
//   rst     in  1  synchronous reset, active-high (q <= rst_val)
//   rst_val in  1  value taken on reset
//   load    in  1  synchronous load enable
//   load_d  in  1  value taken on load
//   t       in  1  toggle request
//   q       out 1  cell state
// ---------------------------------------------------------------------------
module tff_cell (
   input  logic clk,
   input  logic rst,
   input  logic rst_val,
   input  logic load,
   input  logic load_d,
   input  logic t,
   output logic q
);

   logic q_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         q_reg <= rst_val;
      end else if (load) begin
         q_reg <= load_d;
      end else if (t) begin
         q_reg <= ~q_reg;
      end
   end

   assign q = q_reg;

endmodule : tff_cell

// File: rtl/tff_counter_bank.sv
// ---------------------------------------------------------------------------
// tff_counter_bank
//   WIDTH T flip-flop cells sharing one clock. Works as an independent toggle
//   bank or as a synchronous up/down counter, with parallel load, optional
//   saturation at the terminal count and a one-cycle wrap pulse.
// Parameters
//   WIDTH    number of cells / counter bits (>=1)
//   SATURATE 1: hold at the terminal count; 0: modulo-2^WIDTH wrap
//   RST_VAL  value loaded into q on reset
// Ports
//   clk      in  1      rising-edge clock
//   rst      in  1      synchronous reset, active-high
//   en       in  1      global enable (load still honoured when low)
//   mode     in  2      00 BANK, 01 UP, 10 DOWN, 11 HOLD
//   t_in     in  WIDTH  per-bit toggle requests, BANK mode only
//   load     in  1      synchronous parallel load
//   load_val in  WIDTH  value for load
//   q        out WIDTH  cell outputs / count
//   tc       out 1      terminal count (combinational)
//   wrap     out 1      registered pulse: q wrapped on the previous edge
// ---------------------------------------------------------------------------
module tff_counter_bank
   import tff_counter_pkg::*;
#(
   parameter int               WIDTH    = 8,
   parameter bit               SATURATE = 1'b0,
   parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] t_in,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             wrap
);

   logic [WIDTH-1:0] up_t;
   logic [WIDTH-1:0] dn_t;
   logic [WIDTH-1:0] t_sel;
   logic [WIDTH-1:0] t_gated;
   logic             sat_block;
   logic             wrap_reg;
   logic             wrap_next;

   // Terminal count: the next count step would cross the modulo boundary.
   assign tc = ((mode == MODE_UP)   && (&q)) ||
               ((mode == MODE_DOWN) && (q == '0));

   // Toggle chains: a bit flips on increment when every lower bit is 1,
   // and on decrement when every lower bit is 0. Bit 0 always flips.
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chain
      if (gi == 0) begin : g_lsb
         assign up_t[gi] = 1'b1;
         assign dn_t[gi] = 1'b1;
      end else begin : g_upper
         assign up_t[gi] = &q[gi-1:0];
         assign dn_t[gi] = ~|q[gi-1:0];
      end
   end

   always_comb begin
      t_sel = '0;
      case (mode)
         MODE_BANK: t_sel = t_in;
         MODE_UP:   t_sel = up_t;
         MODE_DOWN: t_sel = dn_t;
         default:   t_sel = '0;
      endcase
   end

   // Saturation suppresses every toggle at the boundary so q holds.
   assign sat_block = SATURATE && tc;
   assign t_gated   = (en && !sat_block) ? t_sel : '0;

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      tff_cell u_cell (
         .clk     (clk),
         .rst     (rst),
         .rst_val (RST_VAL[gi]),
         .load    (load),
         .load_d  (load_val[gi]),
         .t       (t_gated[gi]),
         .q       (q[gi])
      );
   end

   // A wrap happens exactly when a count step is taken at the terminal
   // count without saturation; tc already implies UP or DOWN mode.
   assign wrap_next = !load && en && tc && !SATURATE;

   always_ff @(posedge clk) begin
      if (rst) begin
         wrap_reg <= 1'b0;
      end else begin
         wrap_reg <= wrap_next;
      end
   end

   assign wrap = wrap_reg;

endmodule : tff_counter_bank

// File: tb/tb_tff_counter_bank.sv
// ---------------------------------------------------------------------------
// tb_tff_counter_bank
//   Two WIDTH=4, RST_VAL=5 instances (wrapping and saturating) driven by the
//   same stimulus. Expected q/wrap are pushed to a queue when inputs are
//   driven and popped after the edge; tc is checked against the expected q.
// ---------------------------------------------------------------------------
module tb_tff_counter_bank;
   import tff_counter_pkg::*;

   localparam int         W  = 4;
   localparam logic [3:0] RV = 4'h5;

   logic         clk = 1'b0;
   logic         rst;
   logic         en;
   logic [1:0]   mode;
   logic [W-1:0] t_in;
   logic         load;
   logic [W-1:0] load_val;
   logic [W-1:0] q_w, q_s;
   logic         tc_w, tc_s, wrap_w, wrap_s;

   always #5 clk = ~clk;

   tff_counter_bank #(.WIDTH(W), .SATURATE(1'b0), .RST_VAL(RV)) dut_wrap (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .t_in(t_in),
      .load(load), .load_val(load_val), .q(q_w), .tc(tc_w), .wrap(wrap_w)
   );

   tff_counter_bank #(.WIDTH(W), .SATURATE(1'b1), .RST_VAL(RV)) dut_sat (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .t_in(t_in),
      .load(load), .load_val(load_val), .q(q_s), .tc(tc_s), .wrap(wrap_s)
   );

   typedef struct packed {
      logic [3:0] q_w;
      logic       wrap_w;
      logic [3:0] q_s;
      logic       wrap_s;
   } exp_t;

   exp_t       sb_q[$];
   int         n_checks = 0;
   int         n_errors = 0;
   int         n_txn    = 0;
   logic [3:0] m_q_w    = 4'h0;
   logic [3:0] m_q_s    = 4'h0;

   task automatic check_val(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h (txn %0d)", tag, got, exp, n_txn);
      end
   endtask

   // Reference behaviour written as plain arithmetic on the count.
   function automatic logic [4:0] model_next(input logic [3:0] cur, input bit sat);
      logic [3:0] nq;
      logic       nw;
      nq = cur;
      nw = 1'b0;
      if (rst)                              nq = RV;
      else if (load)                        nq = load_val;
      else if (!en || mode == MODE_HOLD)    nq = cur;
      else if (mode == MODE_BANK)           nq = cur ^ t_in;
      else if (mode == MODE_UP) begin
         if (cur == 4'hF) begin
            if (!sat) begin nq = 4'h0; nw = 1'b1; end
         end else nq = cur + 4'h1;
      end else begin
         if (cur == 4'h0) begin
            if (!sat) begin nq = 4'hF; nw = 1'b1; end
         end else nq = cur - 4'h1;
      end
      return {nw, nq};
   endfunction

   function automatic logic exp_tc(input logic [3:0] qq);
      return (mode == MODE_UP && qq == 4'hF) || (mode == MODE_DOWN && qq == 4'h0);
   endfunction

   // Drive is already applied; push expectation, take one edge, compare.
   task automatic step();
      logic [4:0] rw, rs;
      exp_t       e;
      rw = model_next(m_q_w, 1'b0);
      rs = model_next(m_q_s, 1'b1);
      m_q_w = rw[3:0];
      m_q_s = rs[3:0];
      sb_q.push_back({rw[3:0], rw[4], rs[3:0], rs[4]});
      @(posedge clk);
      #1;
      n_txn++;
      e = sb_q.pop_front();
      $display("txn %0d rst=%0b ld=%0b en=%0b mode=%0d t=%h | q_w=%h wrap_w=%0b q_s=%h wrap_s=%0b",
               n_txn, rst, load, en, mode, t_in, q_w, wrap_w, q_s, wrap_s);
      check_val("q_wrap",    q_w,    e.q_w);
      check_val("wrap_wrap", wrap_w, e.wrap_w);
      check_val("q_sat",     q_s,    e.q_s);
      check_val("wrap_sat",  wrap_s, e.wrap_s);
      check_val("tc_wrap",   tc_w,   exp_tc(e.q_w));
      check_val("tc_sat",    tc_s,   exp_tc(e.q_s));
   endtask

   task automatic drive(input logic r, input logic ld, input logic [3:0] lv,
                        input logic e, input logic [1:0] m, input logic [3:0] t);
      rst = r; load = ld; load_val = lv; en = e; mode = m; t_in = t;
   endtask

   initial begin
      drive(1'b1, 1'b0, 4'h0, 1'b0, MODE_HOLD, 4'h0);

      // Reset held two edges.
      step(); step();
      check_val("rst_q", q_w, 4'h5);
      check_val("rst_wrap", wrap_w, 1'b0);

      // Reset in the middle of counting.
      drive(1'b0, 1'b0, 4'h0, 1'b1, MODE_UP, 4'h0); step();
      check_val("up_from_rst", q_w, 4'h6);
      drive(1'b1, 1'b1, 4'hC, 1'b1, MODE_UP, 4'h0); step();
      check_val("rst_mid_count", q_w, 4'h5);

      // UP wrap.
      drive(1'b0, 1'b1, 4'hE, 1'b1, MODE_UP, 4'h0); step();
      drive(1'b0, 1'b0, 4'h0, 1'b1, MODE_UP, 4'h0); step();
      check_val("up_tc", tc_w, 1'b1);
      step();
      check_val("up_wrapped_q", q_w, 4'h0);
      check_val("up_wrap_pulse", wrap_w, 1'b1);
      check_val("sat_up_hold", q_s, 4'hF);
      step();
      check_val("up_after_wrap", q_w, 4'h1);
      check_val("wrap_cleared", wrap_w, 1'b0);

      // DOWN with saturation.
      drive(1'b0, 1'b1, 4'h2, 1'b1, MODE_DOWN, 4'h0); step();
      drive(1'b0, 1'b0, 4'h0, 1'b1, MODE_DOWN, 4'h0);
      for (int i = 0; i < 4; i++) step();
      check_val("down_sat_q", q_s, 4'h0);
      check_val("down_sat_tc", tc_s, 1'b1);

      // BANK toggling, then disabled.
      drive(1'b0, 1'b1, 4'h0, 1'b1, MODE_BANK, 4'h0); step();
      drive(1'b0, 1'b0, 4'h0, 1'b1, MODE_BANK, 4'hA); step();
      check_val("bank_a", q_w, 4'hA);
      step();
      check_val("bank_0", q_w, 4'h0);
      drive(1'b0, 1'b0, 4'h0, 1'b0, MODE_BANK, 4'hA); step();
      check_val("bank_en0", q_w, 4'h0);

      // Priority: load over count, load with en=0, HOLD.
      drive(1'b0, 1'b1, 4'h3, 1'b1, MODE_UP, 4'h0); step();
      drive(1'b0, 1'b1, 4'h9, 1'b1, MODE_UP, 4'h0); step();
      check_val("load_over_up", q_w, 4'h9);
      drive(1'b0, 1'b0, 4'h0, 1'b1, MODE_UP, 4'h0); step();
      drive(1'b0, 1'b1, 4'h9, 1'b0, MODE_UP, 4'h0); step();
      check_val("load_en0", q_w, 4'h9);
      drive(1'b0, 1'b0, 4'h0, 1'b1, MODE_HOLD, 4'hF); step();
      check_val("hold_q", q_w, 4'h9);

      // Random traffic against the model.
      for (int i = 0; i < 200; i++) begin
         drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0),
               4'($urandom), ($urandom_range(0, 4) != 0),
               2'($urandom), 4'($urandom));
         step();
      end

      check_val("sb_empty", sb_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   // Safety net in case the clock ever stalls.
   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule : tb_tff_counter_bank
